fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch front end. It holds the program counter and a small FSM
// that issues requests to instruction memory. It accepts returned
// instructions, and it handles downstream stalls, branch/jump redirects and a
// sticky halt.
//
// Ports
//   clk             rising-edge clock for all state
//   reset           synchronous, active-high reset
//   stall           downstream hold request; the PC does not advance while high
//   redirect_valid  branch/jump redirect strobe
//   redirect_addr   redirect target; bit 0 is forced to 0
//   halt            stop fetching until the next reset
//   imem_ready      instruction memory accepts/returns the current request
//   imem_req        fetch request to instruction memory
//   imem_addr       fetch address (always the current PC)
//   pc_write        high in any cycle the PC register changes
//   fetch_valid     one-cycle pulse: the instruction at fetch_pc is accepted
//   fetch_pc        address of the accepted instruction (always the current PC)
//   flush           one-cycle pulse: discard younger fetched instructions
//   state           current FSM state encoding
//
// Only the PC and the state are registers. Every output is decoded
// combinationally from them and from the current inputs.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  input  logic        halt,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic        pc_write,
  output logic        fetch_valid,
  output logic [15:0] fetch_pc,
  output logic        flush,
  output logic [1:0]  state
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic [1:0]  state_nxt;
  logic        pc_write_fsm;
  logic        fetch_valid_fsm;
  logic        flush_fsm;

  // Redirect targets are halfword aligned. The low bit is dropped rather
  // than trapped.
  logic [15:0] redirect_pc;
  assign redirect_pc = {redirect_addr[15:1], 1'b0};

  // NOTE: every signal assigned in this block gets a default first, so a
  // branch that does not assign it cannot infer a latch.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    imem_req        = 1'b0;
    pc_write_fsm    = 1'b0;
    fetch_valid_fsm = 1'b0;
    flush_fsm       = 1'b0;

    case (state)
      S_BOOT: begin
        state_nxt = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        // Priority: redirect > halt > stall > imem_ready.
        if (redirect_valid) begin
          pc_nxt       = redirect_pc;
          pc_write_fsm = 1'b1;
          flush_fsm    = 1'b1;
          state_nxt    = S_FETCH;
        end else if (halt) begin
          state_nxt = S_HALT;
        end else if (stall) begin
          state_nxt = S_STALL;
        end else if (imem_ready) begin
          // The 16-bit add wraps FFFE -> 0000 with no other side effect.
          pc_nxt          = pc + 16'd2;
          pc_write_fsm    = 1'b1;
          fetch_valid_fsm = 1'b1;
        end
        // imem_ready low with no other event: hold the request and the PC.
      end

      S_STALL: begin
        // imem_ready is irrelevant here because no request is outstanding.
        if (redirect_valid) begin
          pc_nxt       = redirect_pc;
          pc_write_fsm = 1'b1;
          flush_fsm    = 1'b1;
          state_nxt    = S_FETCH;
        end else if (halt) begin
          state_nxt = S_HALT;
        end else if (!stall) begin
          state_nxt = S_FETCH;
        end
      end

      default: begin
        // S_HALT is sticky. Only reset leaves it, so every input is ignored.
        state_nxt = S_HALT;
      end
    endcase
  end

  // A reset in this cycle abandons whatever the FSM was doing. No accept or
  // flush is reported. pc_write still tracks a real PC change caused by
  // the reset load.
  always_comb begin
    if (reset) begin
      pc_write    = (pc != RESET_PC);
      fetch_valid = 1'b0;
      flush       = 1'b0;
    end else begin
      pc_write    = pc_write_fsm;
      fetch_valid = fetch_valid_fsm;
      flush       = flush_fsm;
    end
  end

  assign imem_addr = pc;
  assign fetch_pc  = pc;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= S_BOOT;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. Two instances share one set of inputs:
//   u_dut   RESET_PC = 16'h0000  (main sequence)
//   u_wrap  RESET_PC = 16'hFFFC  (PC wrap-around at the top of the space)
// Inputs change 1 time unit after the rising edge. Outputs are checked 1 time
// unit later, which is well before the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        halt;
  logic        imem_ready;

  logic        imem_req,    w_imem_req;
  logic [15:0] imem_addr,   w_imem_addr;
  logic        pc_write,    w_pc_write;
  logic        fetch_valid, w_fetch_valid;
  logic [15:0] fetch_pc,    w_fetch_pc;
  logic        flush,       w_flush;
  logic [1:0]  state,       w_state;

  int vectors   = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(16'h0000)) u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halt(halt), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc_write(pc_write),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .flush(flush),
    .state(state)
  );

  fetch_sequencer #(.RESET_PC(16'hFFFC)) u_wrap (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halt(halt), .imem_ready(imem_ready),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .pc_write(w_pc_write),
    .fetch_valid(w_fetch_valid), .fetch_pc(w_fetch_pc), .flush(w_flush),
    .state(w_state)
  );

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Settle the combinational outputs after the inputs change.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 16'h0000; halt = 1'b0; imem_ready = 1'b1;

    // ---- Reset, then the S_BOOT cycle ----
    cyc();
    reset = 1'b0; settle();
    check("boot_state",   {14'd0, state},       16'd0);
    check("boot_req",     {15'd0, imem_req},    16'd0);
    check("boot_pcw",     {15'd0, pc_write},    16'd0);
    check("boot_fv",      {15'd0, fetch_valid}, 16'd0);
    check("boot_flush",   {15'd0, flush},       16'd0);
    check("boot_addr",    imem_addr,            16'h0000);
    check("wrap_boot_addr", w_imem_addr,        16'hFFFC);

    // ---- Streaming accepts: 0000, 0002, 0004 (wrap DUT: FFFC, FFFE, 0000) ----
    cyc(); settle();
    check("acc0_state", {14'd0, state},       16'd1);
    check("acc0_req",   {15'd0, imem_req},    16'd1);
    check("acc0_fv",    {15'd0, fetch_valid}, 16'd1);
    check("acc0_pcw",   {15'd0, pc_write},    16'd1);
    check("acc0_pc",    fetch_pc,             16'h0000);
    check("wrap0_pc",   w_fetch_pc,           16'hFFFC);
    check("wrap0_fv",   {15'd0, w_fetch_valid}, 16'd1);
    cyc(); settle();
    check("acc1_pc",  fetch_pc,   16'h0002);
    check("wrap1_pc", w_fetch_pc, 16'hFFFE);
    cyc(); settle();
    check("acc2_pc",  fetch_pc,   16'h0004);
    check("wrap2_pc", w_fetch_pc, 16'h0000);
    cyc(); settle();
    check("wrap3_pc", w_fetch_pc, 16'h0002);

    // ---- imem_ready low for 3 cycles at PC 0006 ----
    imem_ready = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      check("wait_req",  {15'd0, imem_req},    16'd1);
      check("wait_addr", imem_addr,            16'h0006);
      check("wait_fv",   {15'd0, fetch_valid}, 16'd0);
      check("wait_pcw",  {15'd0, pc_write},    16'd0);
      if (i < 2) begin
        cyc(); settle();
      end
    end
    imem_ready = 1'b1; settle();
    check("wait_acc_fv", {15'd0, fetch_valid}, 16'd1);
    check("wait_acc_pc", fetch_pc,             16'h0006);
    cyc(); settle();
    check("after_wait_addr", imem_addr, 16'h0008);

    // Run on to PC 0010.
    cyc(); cyc(); cyc(); cyc(); settle();
    check("pre_stall_addr", imem_addr, 16'h0010);

    // ---- Stall at PC 0010 ----
    stall = 1'b1; settle();
    check("stall_in_fetch_fv",  {15'd0, fetch_valid}, 16'd0);
    check("stall_in_fetch_pcw", {15'd0, pc_write},    16'd0);
    cyc(); settle();
    check("stall_state", {14'd0, state},    16'd2);
    check("stall_req",   {15'd0, imem_req}, 16'd0);
    check("stall_addr",  imem_addr,         16'h0010);
    cyc();
    stall = 1'b0; settle();
    check("stall_rel_state", {14'd0, state},       16'd2);
    check("stall_rel_fv",    {15'd0, fetch_valid}, 16'd0);
    check("stall_rel_pcw",   {15'd0, pc_write},    16'd0);
    cyc(); settle();
    check("resume_state", {14'd0, state},       16'd1);
    check("resume_fv",    {15'd0, fetch_valid}, 16'd1);
    check("resume_pc",    fetch_pc,             16'h0010);

    // ---- Redirect beats stall and ready together, at PC 0012 ----
    cyc();
    redirect_valid = 1'b1; redirect_addr = 16'h1235; stall = 1'b1; settle();
    check("redir_flush", {15'd0, flush},       16'd1);
    check("redir_fv",    {15'd0, fetch_valid}, 16'd0);
    check("redir_pcw",   {15'd0, pc_write},    16'd1);
    cyc();
    redirect_valid = 1'b0; stall = 1'b0; settle();
    check("redir_state", {14'd0, state}, 16'd1);
    check("redir_addr",  imem_addr,      16'h1234);
    check("redir_flush_drop", {15'd0, flush}, 16'd0);
    check("redir_acc_pc", fetch_pc,      16'h1234);

    // ---- Halt beats stall at PC 1236, then redirect is ignored ----
    cyc();
    halt = 1'b1; stall = 1'b1; settle();
    check("halt_fv",  {15'd0, fetch_valid}, 16'd0);
    check("halt_pcw", {15'd0, pc_write},    16'd0);
    cyc();
    halt = 1'b0; stall = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 16'h4000; settle();
    check("halt_state",     {14'd0, state},    16'd3);
    check("halt_req",       {15'd0, imem_req}, 16'd0);
    check("halt_redir_flush", {15'd0, flush},  16'd0);
    check("halt_redir_pcw", {15'd0, pc_write}, 16'd0);
    cyc();
    redirect_valid = 1'b0; settle();
    check("halt_sticky",    {14'd0, state}, 16'd3);
    check("halt_addr",      imem_addr,      16'h1236);

    // ---- Reset out of S_HALT ----
    reset = 1'b1; settle();
    check("halt_rst_fv",    {15'd0, fetch_valid}, 16'd0);
    cyc();
    reset = 1'b0; settle();
    check("halt_rst_state", {14'd0, state}, 16'd0);
    check("halt_rst_addr",  imem_addr,      16'h0000);

    // ---- Reset mid-fetch: no fetch_valid / flush pulse ----
    cyc(); cyc();
    redirect_valid = 1'b1; redirect_addr = 16'h2000;
    reset = 1'b1; settle();
    check("midfetch_rst_fv",    {15'd0, fetch_valid}, 16'd0);
    check("midfetch_rst_flush", {15'd0, flush},       16'd0);
    cyc();
    reset = 1'b0; redirect_valid = 1'b0; settle();
    check("midfetch_rst_state", {14'd0, state}, 16'd0);
    check("midfetch_rst_addr",  imem_addr,      16'h0000);
    check("wrap_rst_addr",      w_imem_addr,    16'hFFFC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
